// File: rtl/cpu_ctrl_sequencer_if.sv
// Handshake bundle between the clock generator / datapath side (master) and the
// instruction-cycle sequencer (slave): fetch/opcode/zero in, decoded controls out.
interface cpu_ctrl_sequencer_if;
    logic       fetch;
    logic [2:0] opcode;
    logic       zero;
    logic       inc_pc;
    logic       load_acc;
    logic       load_pc;
    logic       rd;
    logic       wr;
    logic       load_ir;
    logic       datactl_ena;
    logic       halt;
    logic       ena;
    logic [2:0] state;

    modport master (
        output fetch, opcode, zero,
        input  inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt, ena, state
    );

    modport slave (
        input  fetch, opcode, zero,
        output inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt, ena, state
    );
endinterface

// File: rtl/cpu_ctrl_sequencer.sv
// 8-state instruction-cycle sequencer; controls are registered and valid for the clk1 cycle after the edge entering a state.
// HALT_LATCH_EN: when defined, HLT freezes the sequencer in S3 with halt held until rst.
module cpu_ctrl_sequencer (
    input  logic                 i_clk1,
    input  logic                 i_rst,
    cpu_ctrl_sequencer_if.slave  io_seq
);
    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6, S7} state_t;

    typedef struct packed {
        logic inc_pc;
        logic load_acc;
        logic load_pc;
        logic rd;
        logic wr;
        logic load_ir;
        logic datactl_ena;
        logic halt;
    } ctrl_t;

    state_t r_state;
    logic   r_ena;
    ctrl_t  r_ctrl;
    state_t w_next;
    ctrl_t  w_dec;
`ifdef HALT_LATCH_EN
    logic   r_halted;
`endif

    // Controls for the state being entered, from the opcode/zero seen at this edge.
    function automatic ctrl_t decode(input state_t s, input logic [2:0] op, input logic z);
        ctrl_t c;
        logic  alu;
        logic  skz_z;
        c     = '0;
        alu   = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
        skz_z = (op == OP_SKZ) && z;
        case (s)
            S0: begin
                c.rd      = 1'b1;
                c.load_ir = 1'b1;
            end
            S1: begin
                c.rd      = 1'b1;
                c.load_ir = 1'b1;
                c.inc_pc  = 1'b1;
            end
            S2: ;
            S3: begin
                c.inc_pc = 1'b1;
                c.halt   = (op == OP_HLT);
            end
            S4: begin
                c.rd          = alu;
                c.load_pc     = (op == OP_JMP);
                c.datactl_ena = (op == OP_STO);
                c.inc_pc      = skz_z;
            end
            S5: begin
                c.rd          = alu;
                c.load_acc    = alu;
                c.load_pc     = (op == OP_JMP);
                c.inc_pc      = (op == OP_JMP) || skz_z;
                c.wr          = (op == OP_STO);
                c.datactl_ena = (op == OP_STO);
            end
            S6: begin
                c.rd          = alu;
                c.datactl_ena = (op == OP_STO);
            end
            S7: c.inc_pc = skz_z;
            default: ;
        endcase
        return c;
    endfunction

    // Leaving the idle condition always lands in S0.
    assign w_next = r_ena ? state_t'(r_state + 3'd1) : S0;
    assign w_dec  = decode(w_next, io_seq.opcode, io_seq.zero);

    always_ff @(posedge i_clk1) begin
        if (i_rst) begin
            r_ena   <= 1'b0;
            r_state <= S0;
            r_ctrl  <= '0;
`ifdef HALT_LATCH_EN
            r_halted <= 1'b0;
`endif
        end
`ifdef HALT_LATCH_EN
        else if (r_halted) begin
            r_state <= S3;
        end
`endif
        else if (!r_ena && !io_seq.fetch) begin
            r_ctrl <= '0;
        end else begin
            r_ena   <= 1'b1;
            r_state <= w_next;
            r_ctrl  <= w_dec;
`ifdef HALT_LATCH_EN
            if (w_next == S3 && io_seq.opcode == OP_HLT) begin
                r_halted <= 1'b1;
                r_ctrl   <= '{halt: 1'b1, default: 1'b0};
            end
`endif
        end
    end

    assign io_seq.inc_pc      = r_ctrl.inc_pc;
    assign io_seq.load_acc    = r_ctrl.load_acc;
    assign io_seq.load_pc     = r_ctrl.load_pc;
    assign io_seq.rd          = r_ctrl.rd;
    assign io_seq.wr          = r_ctrl.wr;
    assign io_seq.load_ir     = r_ctrl.load_ir;
    assign io_seq.datactl_ena = r_ctrl.datactl_ena;
    assign io_seq.halt        = r_ctrl.halt;
    assign io_seq.ena         = r_ena;
    assign io_seq.state       = r_state;
endmodule

// File: tb/tb_cpu_ctrl_sequencer.sv
// Bench for cpu_ctrl_sequencer: per-state rule-table model checked every cycle,
// plus literal per-instruction output patterns (bit k = asserted in state k).
module tb_cpu_ctrl_sequencer;
    localparam logic [2:0] HLT = 3'b000, SKZ = 3'b001, ADD = 3'b010, XOR_ = 3'b100;
    localparam logic [2:0] LDA = 3'b101, STO = 3'b110, JMP = 3'b111;

    logic clk1 = 1'b0;
    logic rst  = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;
    logic cmp_on = 1'b0;

    cpu_ctrl_sequencer_if bus ();

    cpu_ctrl_sequencer dut (
        .i_clk1 (clk1),
        .i_rst  (rst),
        .io_seq (bus.slave)
    );

    always #5 clk1 = ~clk1;

    // {ena, state, inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt}
    logic [11:0] act_vec;
    assign act_vec = {bus.ena, bus.state, bus.inc_pc, bus.load_acc, bus.load_pc, bus.rd,
                      bus.wr, bus.load_ir, bus.datactl_ena, bus.halt};

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Model: which states assert each control, as 8-bit masks chosen by opcode class.
    logic [2:0]  m_st;
    logic        m_ena, m_halted;
    logic [11:0] m_exp;
    logic [7:0]  rd_m, ir_m, inc_m, acc_m, pc_m, wr_m, dc_m, h_m;
    logic        is_alu, is_sto, is_jmp, is_skz, is_hlt;

    always @(posedge clk1) begin
        is_alu = bus.opcode inside {3'b010, 3'b011, 3'b100, 3'b101};
        is_sto = bus.opcode == STO;
        is_jmp = bus.opcode == JMP;
        is_skz = bus.opcode == SKZ;
        is_hlt = bus.opcode == HLT;
        if (rst) begin
            m_ena = 1'b0; m_st = 3'd0; m_halted = 1'b0; m_exp = '0;
        end else if (m_halted) begin
            m_exp = {1'b1, 3'd3, 7'b0, 1'b1};
        end else if (!m_ena && !bus.fetch) begin
            m_exp = '0;
        end else begin
            if (!m_ena) begin m_ena = 1'b1; m_st = 3'd0; end
            else m_st = m_st + 3'd1;
            rd_m  = 8'b0000_0011 | (is_alu ? 8'b0111_0000 : 8'h00);
            ir_m  = 8'b0000_0011;
            inc_m = 8'b0000_1010 | ((is_skz && bus.zero) ? 8'b1011_0000 : 8'h00)
                                 | (is_jmp ? 8'b0010_0000 : 8'h00);
            acc_m = is_alu ? 8'b0010_0000 : 8'h00;
            pc_m  = is_jmp ? 8'b0011_0000 : 8'h00;
            wr_m  = is_sto ? 8'b0010_0000 : 8'h00;
            dc_m  = is_sto ? 8'b0111_0000 : 8'h00;
            h_m   = is_hlt ? 8'b0000_1000 : 8'h00;
            m_exp = {1'b1, m_st, inc_m[m_st], acc_m[m_st], pc_m[m_st], rd_m[m_st],
                     wr_m[m_st], ir_m[m_st], dc_m[m_st], h_m[m_st]};
`ifdef HALT_LATCH_EN
            if (is_hlt && m_st == 3'd3) begin
                m_halted = 1'b1;
                m_exp = {1'b1, 3'd3, 7'b0, 1'b1};
            end
`endif
        end
    end

    always @(negedge clk1) begin
        if (cmp_on) chk("model", {4'b0, act_vec}, {4'b0, m_exp});
    end

    // Per-step observations of the last run_instr call.
    logic [7:0] ob_rd, ob_ir, ob_inc, ob_acc, ob_pc, ob_wr, ob_dc, ob_h, ob_seq;

    task automatic step();
        @(posedge clk1);
        @(negedge clk1);
    endtask

    task automatic run_instr(input logic [2:0] op, input logic [7:0] zmask, input int nsteps);
        {ob_rd, ob_ir, ob_inc, ob_acc, ob_pc, ob_wr, ob_dc, ob_h, ob_seq} = '0;
        for (int k = 0; k < nsteps; k++) begin
            bus.opcode = op;
            bus.zero   = zmask[k];
            bus.fetch  = (k < 4);
            step();
            ob_rd[k]  = bus.rd;
            ob_ir[k]  = bus.load_ir;
            ob_inc[k] = bus.inc_pc;
            ob_acc[k] = bus.load_acc;
            ob_pc[k]  = bus.load_pc;
            ob_wr[k]  = bus.wr;
            ob_dc[k]  = bus.datactl_ena;
            ob_h[k]   = bus.halt;
            ob_seq[k] = bus.ena && (bus.state == 3'(k));
        end
    endtask

    initial begin
        int hold_cnt;
        bus.fetch = 1'b0; bus.opcode = HLT; bus.zero = 1'b0;
        rst = 1'b1;
        step();
        cmp_on = 1'b1;
        step();
        chk("reset_state", {4'b0, act_vec}, 16'h0);
        rst = 1'b0;
        repeat (3) step();
        chk("idle_no_fetch", {4'b0, act_vec}, 16'h0);

        run_instr(LDA, 8'h00, 8);
        chk("lda_seq", {8'h0, ob_seq}, 16'h00FF);
        chk("lda_rd", {8'h0, ob_rd}, 16'h0073);
        chk("lda_ir", {8'h0, ob_ir}, 16'h0003);
        chk("lda_acc", {8'h0, ob_acc}, 16'h0020);
        chk("lda_inc", {8'h0, ob_inc}, 16'h000A);

        run_instr(STO, 8'h00, 8);
        chk("sto_dc", {8'h0, ob_dc}, 16'h0070);
        chk("sto_wr", {8'h0, ob_wr}, 16'h0020);
        chk("sto_rd", {8'h0, ob_rd}, 16'h0003);

        run_instr(SKZ, 8'hFF, 8);
        chk("skz_z1_inc", {8'h0, ob_inc}, 16'h00BA);
        run_instr(SKZ, 8'h00, 8);
        chk("skz_z0_inc", {8'h0, ob_inc}, 16'h000A);
        run_instr(SKZ, 8'h10, 8);
        chk("skz_zpulse_inc", {8'h0, ob_inc}, 16'h001A);

        run_instr(JMP, 8'h00, 8);
        chk("jmp_pc", {8'h0, ob_pc}, 16'h0030);
        chk("jmp_inc", {8'h0, ob_inc}, 16'h002A);
        chk("jmp_seq", {8'h0, ob_seq}, 16'h00FF);

        run_instr(ADD, 8'h00, 6);
        chk("add_acc", {8'h0, ob_acc}, 16'h0020);
        rst = 1'b1;
        step();
        chk("rst_mid_add", {4'b0, act_vec}, 16'h0);
        rst = 1'b0;
        bus.fetch = 1'b0;
        repeat (2) step();
        chk("idle_after_rst", {4'b0, act_vec}, 16'h0);
        run_instr(XOR_, 8'h00, 8);
        chk("xor_seq", {8'h0, ob_seq}, 16'h00FF);
        chk("xor_rd", {8'h0, ob_rd}, 16'h0073);

        run_instr(HLT, 8'h00, 8);
`ifdef HALT_LATCH_EN
        chk("hlt_latch_halt", {8'h0, ob_h}, 16'h00F8);
        chk("hlt_latch_inc", {8'h0, ob_inc}, 16'h0002);
        hold_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            bus.opcode = 3'(i);
            bus.fetch  = i[0];
            step();
            if (bus.halt && bus.state == 3'd3 && !bus.inc_pc && !bus.rd) hold_cnt++;
        end
        chk("hlt_latch_hold", 16'(hold_cnt), 16'd20);
        rst = 1'b1;
        step();
        chk("hlt_latch_rst", {4'b0, act_vec}, 16'h0);
        rst = 1'b0;
`else
        chk("hlt_pulse_halt", {8'h0, ob_h}, 16'h0008);
        chk("hlt_pulse_inc", {8'h0, ob_inc}, 16'h000A);
        run_instr(ADD, 8'h00, 8);
        chk("after_hlt_seq", {8'h0, ob_seq}, 16'h00FF);
        chk("after_hlt_rd", {8'h0, ob_rd}, 16'h0073);
`endif
        step();
        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
